// File: rtl/mem_line_pkg.sv
// mem_line_pkg: shared constants and state encoding for the line-granular memory responder.
package mem_line_pkg;
   localparam int LINE_W = 128;
   localparam logic [2:0] RD = 3'd0;
   localparam logic [2:0] WR = 3'd1;
   localparam logic [2:0] INIT = 3'd2;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: line storage with synchronous write and combinational read, contents not reset.
module mem_line_array
   import mem_line_pkg::*;
#(
   parameter int nlines = 256,
   parameter int lidw = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [lidw-1:0]   wr_idx,
   input  logic [LINE_W-1:0] wr_data,
   input  logic [lidw-1:0]   rd_idx,
   output logic [LINE_W-1:0] rd_data
);
   logic [LINE_W-1:0] lines [nlines];
   always_ff @(posedge clk)
      if (wr_en) lines[wr_idx] <= wr_data;
   assign rd_data = lines[rd_idx];
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: blocking single-outstanding line memory with fixed latency and val/rdy response.
module mem_line_responder
   import mem_line_pkg::*;
#(
   parameter int p_mem_nbytes = 4096,
   parameter int p_opaque_nbits = 8,
   parameter int p_latency = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      memreq_val,
   output logic                      memreq_rdy,
   input  logic [2:0]                memreq_type,
   input  logic [p_opaque_nbits-1:0] memreq_opaque,
   input  logic [31:0]               memreq_addr,
   input  logic [3:0]                memreq_len,
   input  logic [LINE_W-1:0]         memreq_data,
   output logic                      memresp_val,
   input  logic                      memresp_rdy,
   output logic [2:0]                memresp_type,
   output logic [p_opaque_nbits-1:0] memresp_opaque,
   output logic [3:0]                memresp_len,
   output logic [LINE_W-1:0]         memresp_data
);
   localparam int nlines = p_mem_nbytes / 16;
   localparam int lidw = $clog2(nlines);
   state_t state, state_nxt;
   logic [3:0] cnt;
   logic [2:0] type_q, type_src;
   logic [p_opaque_nbits-1:0] opaque_q, opaque_src;
   logic [lidw-1:0] idx_q, idx_src, req_idx;
   logic [LINE_W-1:0] rd_data;
   logic req_fire, resp_fire, wr_en, load_resp, unused;
   assign req_idx = memreq_addr[lidw+3:4];
   assign memreq_rdy = state == IDLE && !reset;
   assign memresp_val = state == RESP;
   assign memresp_len = '0;
   assign req_fire = memreq_val && memreq_rdy;
   assign resp_fire = memresp_val && memresp_rdy;
   assign wr_en = req_fire && (memreq_type == WR || memreq_type == INIT);
   // With zero latency RESP is entered straight from IDLE, so the live request feeds the response.
   assign type_src = state == IDLE ? memreq_type : type_q;
   assign opaque_src = state == IDLE ? memreq_opaque : opaque_q;
   assign idx_src = state == IDLE ? req_idx : idx_q;
   assign load_resp = state_nxt == RESP && state != RESP;
   assign unused = ^{memreq_len, memreq_addr[3:0], memreq_addr[31:lidw+4]};
   mem_line_array #(.nlines(nlines), .lidw(lidw)) u_array (
      .clk(clk),
      .wr_en(wr_en),
      .wr_idx(req_idx),
      .wr_data(memreq_data),
      .rd_idx(idx_src),
      .rd_data(rd_data)
   );
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_fire) state_nxt = p_latency == 0 ? RESP : WAIT;
         WAIT: if (cnt == 4'd1) state_nxt = RESP;
         RESP: if (resp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         cnt <= '0;
         type_q <= '0;
         opaque_q <= '0;
         idx_q <= '0;
         memresp_type <= '0;
         memresp_opaque <= '0;
         memresp_data <= '0;
      end else begin
         if (req_fire) begin
            type_q <= memreq_type;
            opaque_q <= memreq_opaque;
            idx_q <= req_idx;
            cnt <= 4'(p_latency);
         end else if (state == WAIT) cnt <= cnt - 4'd1;
         if (load_resp) begin
            memresp_type <= type_src;
            memresp_opaque <= opaque_src;
            memresp_data <= type_src == RD ? rd_data : '0;
         end
      end
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: drives a latency-2 and a latency-0 responder against a line-array model.
module tb_mem_line_responder;
   logic clk = 0;
   logic reset = 1;
   logic rq_val [2];
   logic rq_rdy [2];
   logic [2:0] rq_type [2];
   logic [7:0] rq_op [2];
   logic [31:0] rq_addr [2];
   logic [3:0] rq_len [2];
   logic [127:0] rq_data [2];
   logic rs_val [2];
   logic rs_rdy [2];
   logic [2:0] rs_type [2];
   logic [7:0] rs_op [2];
   logic [3:0] rs_len [2];
   logic [127:0] rs_data [2];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int lat [2] = '{2, 0};
   logic [127:0] mem_m [2][256];
   bit known [2][256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_line_responder #(.p_mem_nbytes(4096), .p_opaque_nbits(8), .p_latency(2)) u0 (
      .clk(clk), .reset(reset),
      .memreq_val(rq_val[0]), .memreq_rdy(rq_rdy[0]), .memreq_type(rq_type[0]),
      .memreq_opaque(rq_op[0]), .memreq_addr(rq_addr[0]), .memreq_len(rq_len[0]),
      .memreq_data(rq_data[0]), .memresp_val(rs_val[0]), .memresp_rdy(rs_rdy[0]),
      .memresp_type(rs_type[0]), .memresp_opaque(rs_op[0]), .memresp_len(rs_len[0]),
      .memresp_data(rs_data[0])
   );
   mem_line_responder #(.p_mem_nbytes(4096), .p_opaque_nbits(8), .p_latency(0)) u1 (
      .clk(clk), .reset(reset),
      .memreq_val(rq_val[1]), .memreq_rdy(rq_rdy[1]), .memreq_type(rq_type[1]),
      .memreq_opaque(rq_op[1]), .memreq_addr(rq_addr[1]), .memreq_len(rq_len[1]),
      .memreq_data(rq_data[1]), .memresp_val(rs_val[1]), .memresp_rdy(rs_rdy[1]),
      .memresp_type(rs_type[1]), .memresp_opaque(rs_op[1]), .memresp_len(rs_len[1]),
      .memresp_data(rs_data[1])
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction; junk is held on the request bus while busy to show it is ignored.
   task automatic txn(input int d, input logic [2:0] t, input logic [31:0] a, input logic [127:0] wd,
                      input logic [7:0] op, input int stall, output int acc);
      int idx, k;
      logic [127:0] ed;
      idx = int'((a % 32'd4096) / 32'd16);
      ed = t == 3'd0 ? mem_m[d][idx] : '0;
      if (t == 3'd1 || t == 3'd2) begin
         mem_m[d][idx] = wd;
         known[d][idx] = 1;
      end
      check("req_rdy_idle", rq_rdy[d], 1);
      rq_val[d] = 1; rq_type[d] = t; rq_addr[d] = a; rq_data[d] = wd; rq_op[d] = op;
      rq_len[d] = 4'($urandom);
      @(posedge clk);
      acc = cyc;
      #1;
      rq_type[d] = t ^ 3'd1; rq_addr[d] = a + 32'h10; rq_data[d] = ~wd; rq_op[d] = ~op;
      k = 0;
      while (rs_val[d] !== 1'b1 && k < 40) begin
         check("req_rdy_busy", rq_rdy[d], 0);
         @(posedge clk);
         #1;
         k++;
      end
      check("latency", 128'(k), 128'(lat[d]));
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) begin
            @(posedge clk);
            #1;
         end
         check("resp_val", rs_val[d], 1);
         check("req_rdy_resp", rq_rdy[d], 0);
         check("resp_type", rs_type[d], t);
         check("resp_opaque", rs_op[d], op);
         check("resp_len", rs_len[d], 0);
         check("resp_data", rs_data[d], ed);
      end
      rq_val[d] = 0;
      rs_rdy[d] = 1;
      @(posedge clk);
      #1;
      rs_rdy[d] = 0;
      check("resp_single_fire", rs_val[d], 0);
      check("req_rdy_after", rq_rdy[d], 1);
   endtask

   initial begin
      int acc, acc1, acc2, d, idx, r;
      logic [2:0] t;
      logic [31:0] a;
      logic [127:0] va, vb, vc;
      for (int i = 0; i < 2; i++) begin
         rq_val[i] = 0; rq_type[i] = 0; rq_op[i] = 0; rq_addr[i] = 0;
         rq_len[i] = 0; rq_data[i] = 0; rs_rdy[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("reset_req_rdy", rq_rdy[i], 0);
         check("reset_resp_val", rs_val[i], 0);
         check("reset_resp_type", rs_type[i], 0);
         check("reset_resp_opaque", rs_op[i], 0);
         check("reset_resp_len", rs_len[i], 0);
         check("reset_resp_data", rs_data[i], 0);
      end
      reset = 0;
      #1;
      check("post_reset_rdy", rq_rdy[0], 1);
      // Write-init then read back
      txn(0, 3'd2, 32'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 8'h11, 0, acc);
      txn(0, 3'd0, 32'h40, 128'h0, 8'h5A, 0, acc);
      txn(0, 3'd0, 32'h40, 128'h0, 8'h33, 5, acc);
      // Address wrap modulo 4096 bytes
      va = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 3'd1, 32'h00001010, va, 8'h21, 0, acc);
      txn(0, 3'd0, 32'h00000010, 128'h0, 8'h22, 1, acc);
      vb = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 3'd1, 32'hFFFFFFF0, vb, 8'h23, 0, acc);
      txn(0, 3'd0, 32'h00000FF0, 128'h0, 8'h24, 0, acc);
      // Unsupported type leaves storage untouched
      vb = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 3'd1, 32'h30, vb, 8'h31, 0, acc);
      txn(0, 3'd5, 32'h30, ~vb, 8'h32, 2, acc);
      txn(0, 3'd0, 32'h30, 128'h0, 8'h33, 0, acc);
      // Zero latency: back-to-back reads every two cycles
      txn(1, 3'd1, 32'h100, {$urandom, $urandom, $urandom, $urandom}, 8'h41, 0, acc);
      txn(1, 3'd1, 32'h110, {$urandom, $urandom, $urandom, $urandom}, 8'h42, 0, acc);
      txn(1, 3'd0, 32'h100, 128'h0, 8'h43, 0, acc1);
      txn(1, 3'd0, 32'h110, 128'h0, 8'h44, 0, acc2);
      check("b2b_spacing", 128'(acc2 - acc1), 128'd2);
      // Reset during WAIT drops the response but keeps the write
      vc = {$urandom, $urandom, $urandom, $urandom};
      mem_m[0][7] = vc;
      known[0][7] = 1;
      rq_val[0] = 1; rq_type[0] = 3'd1; rq_addr[0] = 32'h70; rq_data[0] = vc; rq_op[0] = 8'h77;
      @(posedge clk);
      #1;
      rq_val[0] = 0;
      check("rst_wait_val", rs_val[0], 0);
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      #1;
      check("rst_req_rdy", rq_rdy[0], 1);
      check("rst_resp_val", rs_val[0], 0);
      repeat (6) begin
         @(posedge clk);
         #1;
         check("rst_no_resp", rs_val[0], 0);
      end
      txn(0, 3'd0, 32'h70, 128'h0, 8'h78, 0, acc);
      // Randomized mix on both instances
      for (int i = 0; i < 40; i++) begin
         d = $urandom_range(0, 1);
         idx = $urandom_range(16, 47);
         r = $urandom_range(0, 9);
         t = r < 3 ? 3'd1 : r < 4 ? 3'd2 : r < 8 ? 3'd0 : 3'($urandom_range(3, 7));
         if (t == 3'd0 && !known[d][idx]) t = 3'd1;
         a = ($urandom & 32'hFFFF_F00F) | (32'(idx) << 4);
         txn(d, t, a, {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), acc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Synthesizable blocking memory responder: the far end of the cache's memreq/memresp port.
- Accepts one 128-bit cache-line request at a time (refill read, evict write, write-init).
- Applies a fixed configurable latency, then returns one response through a val/rdy handshake.
- Used as the backing store under the blocking cache in lab3 system and integration benches.

Parameters:
- p_mem_nbytes, 4096, storage size in bytes; must be a power of two and >= 16
- p_opaque_nbits, 8, opaque field width, echoed unchanged
- p_latency, 2, extra cycles between accept and response-valid; range 0..15
- nlines (local), p_mem_nbytes/16, number of 128-bit lines
- lidw (local), $clog2(nlines), line index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- memreq_val  in  1  request valid
- memreq_rdy  out  1  request ready
- memreq_type  in  3  0=read, 1=write, 2=write-init, others unsupported
- memreq_opaque  in  p_opaque_nbits  tag echoed in the response
- memreq_addr  in  32  byte address; bits [3:0] ignored
- memreq_len  in  4  0 = full line; ignored
- memreq_data  in  128  write line data
- memresp_val  out  1  response valid
- memresp_rdy  in  1  response ready
- memresp_type  out  3  echo of request type
- memresp_opaque  out  p_opaque_nbits  echo of request opaque
- memresp_len  out  4  always 0
- memresp_data  out  128  line data for reads; 0 otherwise

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, memreq_rdy=0 during the reset cycle, memresp_val=0, all memresp fields 0, latency counter 0.
- Storage contents are not reset. Contents are undefined until written.
- Line index = memreq_addr[lidw+3:4]. Higher address bits are ignored, so addresses wrap modulo p_mem_nbytes.

States:
- IDLE
  - memreq_rdy=1 when not in reset; memresp_val=0.
  - On fire (val&&rdy): latch type, opaque and index.
  - Type 1 or 2: write memreq_data to the indexed line at this same edge.
  - Next state is RESP if p_latency==0, otherwise WAIT with cnt=p_latency.
- WAIT
  - memreq_rdy=0, memresp_val=0.
  - cnt decrements each cycle; when cnt==1, go to RESP at the next edge.
  - WAIT therefore lasts exactly p_latency cycles.
- RESP
  - memresp_val=1, memreq_rdy=0.
  - memresp_data = indexed line for type 0; 0 for all other types.
  - All response fields are registered on entry to RESP and held stable until fire.
  - On memresp_rdy: go to IDLE at the next edge.
  - If memresp_rdy stays low, stay in RESP indefinitely with fields unchanged.

Latency and throughput:
- Accept at edge N; memresp_val is first high in cycle N+1+p_latency.
- Minimum period is p_latency+2 cycles per transaction. No accept in the same cycle as a response fire.

Ordering and boundary cases:
- A read following a write to the same line returns the written data.
- Unsupported types (3..7): no storage write; respond with the echoed type, data 0, same latency.
- memreq_val asserted outside IDLE: ignored, not latched, since rdy=0.
- Reset mid-transaction: the pending response is dropped and no memresp is produced. A write committed at accept remains in storage.
- Max address 0xFFFFFFF0 wraps to line nlines-1.

Decomposition:
- Shared package mem_line_pkg holds:
  - the request/response type constants (RD=0, WR=1, INIT=2);
  - the state enum {IDLE, WAIT, RESP};
  - the line width constant 128.
- One sub-module, mem_line_array: nlines x 128 storage with synchronous write and combinational read.
- FSM, latency counter and response registers stay in mem_line_responder.

Test Plan:
- Write-init then read, p_latency=2: INIT addr 0x00000040 data 0x0123..CDEF, then READ addr 0x00000040 opaque 0x5A. Required: INIT response has type 2, data 0. READ response has type 0, opaque 0x5A, data 0x0123..CDEF. memresp_val rises exactly 3 cycles after each accept.
- Backpressure: hold memresp_rdy=0 for 5 cycles in RESP. Required: memresp_val stays 1, all fields are stable, memreq_rdy=0 throughout, and exactly one fire occurs when rdy rises.
- Wrap-around, p_mem_nbytes=4096: WR 0x00001010 data A, then READ 0x00000010. Required: data A is returned. Also WR 0xFFFFFFF0 followed by READ 0x00000FF0 returns the same line.
- p_latency=0: back-to-back READs with memresp_rdy=1. Required: memresp_val appears the cycle after accept, and requests are accepted every 2 cycles.
- Unsupported type 5 to line 3 holding B. Required: response type 5, data 0, and a later READ of line 3 still returns B.
- Reset asserted during WAIT after a WR of C to line 7. Required: no response after reset, memreq_rdy=1 the cycle after reset deasserts, and READ of line 7 returns C.
